// File: rtl/mux_share_arbiter_if.sv
// Bundle of request, data, handshake and grant signals shared between the
// requesters/consumer (master side) and the arbiter (slave side).
interface mux_share_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ready;
  logic             grant_a;
  logic             grant_b;
  logic             sel;
  logic [WIDTH-1:0] z;
  logic             z_valid;

  // Requesters and downstream consumer drive requests/data/ready.
  modport master (
    output req_a, data_a, req_b, data_b, ready,
    input  grant_a, grant_b, sel, z, z_valid
  );

  // The arbiter consumes requests and drives grants, select and the mux output.
  modport slave (
    input  req_a, data_a, req_b, data_b, ready,
    output grant_a, grant_b, sel, z, z_valid
  );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux (z = a & ~c | b & c) between
// requesters A and B. The grant and the select line are registered; a
// per-grant transfer budget forces a hand-over after MAX_HOLD beats whenever
// the other side is waiting.
module mux_share_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mux_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // hold_cnt only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int              CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic            SIDE_A    = 1'b0;
  localparam logic            SIDE_B    = 1'b1;

  state_t          state_reg, state_next;
  logic [CW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic            last_served_reg, last_served_next;
  logic            sel_reg, sel_next;

  logic            grant_a;
  logic            grant_b;
  logic            z_valid;
  logic            transfer;
  logic            req_own;
  logic            req_other;
  logic            own_side;
  state_t          other_state;

  assign grant_a  = (state_reg == GNT_A);
  assign grant_b  = (state_reg == GNT_B);
  // Valid is purely combinational so an async reset (which clears the state)
  // drops it immediately.
  assign z_valid  = (grant_a & bus.req_a) | (grant_b & bus.req_b);
  assign transfer = z_valid & bus.ready;

  assign bus.grant_a = grant_a;
  assign bus.grant_b = grant_b;
  assign bus.sel     = sel_reg;
  assign bus.z_valid = z_valid;

  // Shared selector, one AND-OR gate pair per bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
      assign bus.z[gi] = (bus.data_a[gi] & ~sel_reg) | (bus.data_b[gi] & sel_reg);
    end
  endgenerate

  // Next-state, budget counter and round-robin pointer.
  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    last_served_next = last_served_reg;
    req_own          = 1'b0;
    req_other        = 1'b0;
    own_side         = SIDE_A;
    other_state      = GNT_B;

    case (state_reg)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          // Tie: the side that was not served last wins.
          state_next = (last_served_reg == SIDE_B) ? GNT_A : GNT_B;
        end else if (bus.req_a) begin
          state_next = GNT_A;
        end else if (bus.req_b) begin
          state_next = GNT_B;
        end
      end

      GNT_A, GNT_B: begin
        // Fold both grant states onto "own" and "other" sides.
        if (state_reg == GNT_A) begin
          req_own     = bus.req_a;
          req_other   = bus.req_b;
          own_side    = SIDE_A;
          other_state = GNT_B;
        end else begin
          req_own     = bus.req_b;
          req_other   = bus.req_a;
          own_side    = SIDE_B;
          other_state = GNT_A;
        end

        if (!req_own) begin
          // Owner let go (with or without a beat): hand over or go idle.
          state_next       = req_other ? other_state : IDLE;
          last_served_next = own_side;
          hold_cnt_next    = '0;
        end else if (transfer) begin
          if ((hold_cnt_reg == HOLD_LAST) && req_other) begin
            // Budget spent and the other side is waiting: switch.
            state_next       = other_state;
            last_served_next = own_side;
            hold_cnt_next    = '0;
          end else if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + CW'(1);
          end
          // else: lone requester with a full budget, counter saturates.
        end
        // No transfer: grant kept, counter frozen.
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Select follows the granted side and holds its value while idle.
    case (state_next)
      GNT_A:   sel_next = 1'b0;
      GNT_B:   sel_next = 1'b1;
      default: sel_next = sel_reg;
    endcase
  end

  // Registered arbiter state with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      last_served_reg <= SIDE_B;
      sel_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      last_served_reg <= last_served_next;
      sel_reg         <= sel_next;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter (WIDTH = 4, MAX_HOLD = 4).
// data_a = 4'b0011 and data_b = 4'b0101 put every (a, b) bit pair on the
// mux under both select values.
module tb_mux_share_arbiter;

  localparam int WIDTH = 4;
  localparam logic [WIDTH-1:0] DA = 4'b0011;
  localparam logic [WIDTH-1:0] DB = 4'b0101;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  mux_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_share_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      $display("  ok   %-16s = %0h", tag, obs);
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held with both sides requesting.
    reset_n      = 1'b0;
    bus.req_a    = 1'b1;
    bus.req_b    = 1'b1;
    bus.data_a   = DA;
    bus.data_b   = DB;
    bus.ready    = 1'b1;
    #1;
    chk("rst_grant_a", bus.grant_a, 0);
    chk("rst_grant_b", bus.grant_b, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_z_valid", bus.z_valid, 0);
    chk("rst_z", bus.z, DA);
    tick();
    chk("rst_edge_grant", {bus.grant_a, bus.grant_b}, 0);
    reset_n = 1'b1;
    #1;
    chk("idle_z_valid", bus.z_valid, 0);
    tick();

    // Fairness: both requesting, ready high -> 4 A beats, 4 B beats, repeat.
    for (int i = 0; i < 16; i++) begin
      logic exp_b;
      exp_b = ((i / 4) % 2) == 1;
      #1;
      chk($sformatf("fair%0d_ga", i), bus.grant_a, !exp_b);
      chk($sformatf("fair%0d_gb", i), bus.grant_b, exp_b);
      chk($sformatf("fair%0d_sel", i), bus.sel, exp_b);
      chk($sformatf("fair%0d_z", i), bus.z, exp_b ? DB : DA);
      chk($sformatf("fair%0d_zv", i), bus.z_valid, 1);
      tick();
    end

    // Backpressure on a fresh A grant: grant held, z stable even if data_b moves.
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.data_b = 4'b1010;
      #1;
      chk($sformatf("bp%0d_ga", i), bus.grant_a, 1);
      chk($sformatf("bp%0d_zv", i), bus.z_valid, 1);
      chk($sformatf("bp%0d_z", i), bus.z, DA);
      tick();
    end
    bus.data_b = DB;
    bus.ready  = 1'b1;
    // Budget was frozen at zero: exactly 4 A beats, then B.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_rel%0d_ga", i), bus.grant_a, 1);
      tick();
    end
    #1;
    chk("bp_switch_gb", bus.grant_b, 1);
    chk("bp_switch_sel", bus.sel, 1);
    chk("bp_switch_z", bus.z, DB);

    // B drops without a beat while A waits -> A granted next edge.
    bus.req_b = 1'b0;
    #1;
    chk("drop_b_zv", bus.z_valid, 0);
    tick();
    // Lone requester: 10 A beats, no switch.
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("lone%0d_ga", i), bus.grant_a, 1);
      chk($sformatf("lone%0d_gb", i), bus.grant_b, 0);
      chk($sformatf("lone%0d_zv", i), bus.z_valid, 1);
      tick();
    end
    // Counter saturated at MAX_HOLD-1: one more A beat, then B.
    bus.req_b = 1'b1;
    #1;
    chk("lone_last_ga", bus.grant_a, 1);
    tick();
    #1;
    chk("lone_switch_gb", bus.grant_b, 1);
    chk("lone_switch_sel", bus.sel, 1);

    // Both let go -> IDLE, sel keeps its last value (B).
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    #1;
    chk("drop_all_zv", bus.z_valid, 0);
    tick();
    #1;
    chk("idle_grants", {bus.grant_a, bus.grant_b}, 0);
    chk("idle_sel_hold", bus.sel, 1);
    chk("idle_z", bus.z, DB);
    chk("idle_zv", bus.z_valid, 0);
    tick();
    #1;
    chk("idle2_grants", {bus.grant_a, bus.grant_b}, 0);

    // Only B from IDLE -> GNT_B.
    bus.req_b = 1'b1;
    tick();
    #1;
    chk("only_b_gb", bus.grant_b, 1);
    chk("only_b_zv", bus.z_valid, 1);

    // B drops, A requests -> GNT_A with last_served = B.
    bus.req_b = 1'b0;
    bus.req_a = 1'b1;
    tick();
    #1;
    chk("b_to_a_ga", bus.grant_a, 1);
    chk("b_to_a_sel", bus.sel, 0);
    chk("b_to_a_z", bus.z, DA);

    // A drops alone -> IDLE with last_served = A.
    bus.req_a = 1'b0;
    tick();
    #1;
    chk("a_idle_grants", {bus.grant_a, bus.grant_b}, 0);
    chk("a_idle_sel", bus.sel, 0);

    // Only A from IDLE -> GNT_A while last_served is still A.
    bus.req_a = 1'b1;
    tick();
    bus.req_b = 1'b1;
    #1;
    chk("burst1_ga", bus.grant_a, 1);
    chk("burst1_zv", bus.z_valid, 1);
    tick();
    #1;
    chk("burst2_ga", bus.grant_a, 1);
    // Async reset between edges during the 2nd A beat.
    reset_n = 1'b0;
    #1;
    chk("arst_ga", bus.grant_a, 0);
    chk("arst_gb", bus.grant_b, 0);
    chk("arst_zv", bus.z_valid, 0);
    chk("arst_sel", bus.sel, 0);
    tick();
    reset_n = 1'b1;
    #1;
    tick();
    // last_served returned to B, so A wins the tie.
    #1;
    chk("post_rst_ga", bus.grant_a, 1);
    chk("post_rst_gb", bus.grant_b, 0);
    chk("post_rst_z", bus.z, DA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
